// File: rtl/osc_tick_gen_if.sv
// Interface bundling the period-load inputs and the timing outputs of osc_tick_gen.
// Latency: none (wires only); the generator registers every output it drives here.
// Backpressure: none; strobes are fire-and-forget clock enables, PERIOD_LD is a one-cycle pulse.
//
// Signals:
//   PERIOD     programmable strobe period in CLK cycles (0 = disabled)
//   PERIOD_LD  one-cycle load strobe for PERIOD
//   READY      high once the power-on stretch has expired
//   TICK_1MHZ / TICK_1KHZ / TICK_1HZ  cascaded one-cycle enable strobes
//   TICK_PROG  one-cycle strobe every active-period cycles
//   UPTIME_S   seconds since READY rose
// Modports: master = the fabric side that loads periods and consumes ticks,
//           slave  = the tick generator itself.

interface osc_tick_gen_if #(
   parameter int PERIOD_W = 24
);
   logic [PERIOD_W-1:0] PERIOD;
   logic                PERIOD_LD;
   logic                READY;
   logic                TICK_1MHZ;
   logic                TICK_1KHZ;
   logic                TICK_1HZ;
   logic                TICK_PROG;
   logic [31:0]         UPTIME_S;

   modport master (
      output PERIOD, PERIOD_LD,
      input  READY, TICK_1MHZ, TICK_1KHZ, TICK_1HZ, TICK_PROG, UPTIME_S
   );

   modport slave (
      input  PERIOD, PERIOD_LD,
      output READY, TICK_1MHZ, TICK_1KHZ, TICK_1HZ, TICK_PROG, UPTIME_S
   );
endinterface

// File: rtl/osc_tick_gen.sv
// Fabric timing source: POR-stretched READY, cascaded 1 MHz/1 kHz/1 Hz strobes, programmable strobe, uptime.
// Latency: every output is a flop; strobes appear the cycle after their counter reaches terminal count.
// Backpressure: none; strobes are single-cycle enables and cannot be stalled.
//
// Ports:
//   CLK  fabric clock (50 MHz RC oscillator)
//   RST  synchronous active-high reset; clears all counters, the active period and every output
//   bus  osc_tick_gen_if.slave: PERIOD/PERIOD_LD in, READY/TICK_*/UPTIME_S out

module osc_tick_gen #(
   parameter int US_DIV     = 50,
   parameter int MS_DIV     = 1000,
   parameter int S_DIV      = 1000,
   parameter int POR_CYCLES = 1024,
   parameter int PERIOD_W   = 24
) (
   input  logic          CLK,
   input  logic          RST,
   osc_tick_gen_if.slave bus
);

   localparam int POR_W = $clog2(POR_CYCLES + 1);
   localparam int US_W  = $clog2(US_DIV);
   localparam int MS_W  = $clog2(MS_DIV);
   localparam int S_W   = $clog2(S_DIV);

   typedef enum logic {
      S_POR_WAIT = 1'b0,
      S_RUN      = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [POR_W-1:0]    por_cnt_q, por_cnt_d;
   logic                run;
   logic                ready_q, ready_d;

   logic [US_W-1:0]     us_cnt_q, us_cnt_d;
   logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
   logic [S_W-1:0]      s_cnt_q, s_cnt_d;
   logic                us_wrap, ms_wrap, s_wrap;
   logic                tick_1mhz_q, tick_1mhz_d;
   logic                tick_1khz_q, tick_1khz_d;
   logic                tick_1hz_q, tick_1hz_d;
   logic [31:0]         uptime_q, uptime_d;

   logic [PERIOD_W-1:0] shadow_q, shadow_d;
   logic [PERIOD_W-1:0] active_q, active_d;
   logic [PERIOD_W-1:0] prog_cnt_q, prog_cnt_d;
   logic                prog_immediate, prog_boundary;
   logic                tick_prog_q, tick_prog_d;

   // ---------------------------------------------------------------
   // POR FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_POR_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // POR FSM: next state. The stretch counter counts every RST=0 edge;
   // the move to RUN happens on the edge after it has seen POR_CYCLES of them,
   // so READY (which mirrors the next state) rises POR_CYCLES edges after release.
   always_comb begin
      state_d   = state_q;
      por_cnt_d = por_cnt_q;
      if (state_q == S_POR_WAIT) begin
         if (por_cnt_q == POR_W'(POR_CYCLES)) begin
            state_d = S_RUN;
         end else begin
            por_cnt_d = por_cnt_q + POR_W'(1);
         end
      end
   end

   // POR FSM: outputs
   always_comb begin
      run     = (state_q == S_RUN);
      ready_d = (state_d == S_RUN);
   end

   // ---------------------------------------------------------------
   // Prescaler cascade. Each level advances only on the wrap pulse of
   // the level below, so coincident strobes line up in the same cycle.
   // ---------------------------------------------------------------
   always_comb begin
      us_wrap  = run && (us_cnt_q == US_W'(US_DIV - 1));
      ms_wrap  = us_wrap && (ms_cnt_q == MS_W'(MS_DIV - 1));
      s_wrap   = ms_wrap && (s_cnt_q == S_W'(S_DIV - 1));

      us_cnt_d = us_cnt_q;
      ms_cnt_d = ms_cnt_q;
      s_cnt_d  = s_cnt_q;
      if (run) begin
         us_cnt_d = us_wrap ? '0 : us_cnt_q + US_W'(1);
      end
      if (us_wrap) begin
         ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + MS_W'(1);
      end
      if (ms_wrap) begin
         s_cnt_d = s_wrap ? '0 : s_cnt_q + S_W'(1);
      end

      tick_1mhz_d = us_wrap;
      tick_1khz_d = ms_wrap;
      tick_1hz_d  = s_wrap;

      // Counts the registered 1 Hz strobe, so it steps on the edge after it.
      uptime_d    = uptime_q + {31'd0, tick_1hz_q};
   end

   // ---------------------------------------------------------------
   // Programmable strobe. The shadow always holds the latest loaded
   // value, so copying it at every boundary both applies pending loads
   // and is a no-op otherwise. A load landing on a boundary is taken
   // directly from the input so the newest value wins.
   // ---------------------------------------------------------------
   always_comb begin
      shadow_d       = bus.PERIOD_LD ? bus.PERIOD : shadow_q;
      prog_immediate = bus.PERIOD_LD && ((active_q == '0) || !run);
      prog_boundary  = run && (active_q != '0) &&
                       (prog_cnt_q == active_q - PERIOD_W'(1));

      active_d   = active_q;
      prog_cnt_d = prog_cnt_q;
      if (prog_immediate) begin
         active_d   = bus.PERIOD;
         prog_cnt_d = '0;
      end else if (prog_boundary) begin
         active_d   = shadow_d;
         prog_cnt_d = '0;
      end else if (run && (active_q != '0)) begin
         prog_cnt_d = prog_cnt_q + PERIOD_W'(1);
      end

      // The completing strobe belongs to the old period.
      tick_prog_d = prog_boundary;
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         por_cnt_q   <= '0;
         ready_q     <= 1'b0;
         us_cnt_q    <= '0;
         ms_cnt_q    <= '0;
         s_cnt_q     <= '0;
         tick_1mhz_q <= 1'b0;
         tick_1khz_q <= 1'b0;
         tick_1hz_q  <= 1'b0;
         uptime_q    <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         prog_cnt_q  <= '0;
         tick_prog_q <= 1'b0;
      end else begin
         por_cnt_q   <= por_cnt_d;
         ready_q     <= ready_d;
         us_cnt_q    <= us_cnt_d;
         ms_cnt_q    <= ms_cnt_d;
         s_cnt_q     <= s_cnt_d;
         tick_1mhz_q <= tick_1mhz_d;
         tick_1khz_q <= tick_1khz_d;
         tick_1hz_q  <= tick_1hz_d;
         uptime_q    <= uptime_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         prog_cnt_q  <= prog_cnt_d;
         tick_prog_q <= tick_prog_d;
      end
   end

   assign bus.READY     = ready_q;
   assign bus.TICK_1MHZ = tick_1mhz_q;
   assign bus.TICK_1KHZ = tick_1khz_q;
   assign bus.TICK_1HZ  = tick_1hz_q;
   assign bus.TICK_PROG = tick_prog_q;
   assign bus.UPTIME_S  = uptime_q;

endmodule

// File: tb/tb_osc_tick_gen.sv
// Testbench for osc_tick_gen: directed scenarios plus randomized period loads and resets,
// checked every cycle against a time-based reference model.
// Edge index e counts rising edges with RST=0 since the last reset, starting at 0.

module tb_osc_tick_gen;

   localparam int US  = 4;
   localparam int MS  = 3;
   localparam int S   = 2;
   localparam int POR = 16;
   localparam int PW  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   osc_tick_gen_if #(.PERIOD_W(PW)) bus ();

   osc_tick_gen #(
      .US_DIV    (US),
      .MS_DIV    (MS),
      .S_DIV     (S),
      .POR_CYCLES(POR),
      .PERIOD_W  (PW)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: everything derived from t = number of RST=0 edges since reset.
   longint      t = 0;
   bit          m_ready, m_mhz, m_khz, m_hz, m_prog;
   logic [31:0] m_up;
   int          m_act, m_shadow;
   longint      m_next;

   bit          rec_prog = 1'b0;
   int          prog_edges[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int cur_e();
      return int'(t) - 1;
   endfunction

   // Advance the model across one rising edge given the inputs sampled there.
   task automatic model_edge(input bit r, input bit ld, input int per);
      bit     run_before;
      bit     prev_hz;
      longint rr;
      if (r) begin
         t = 0;
         m_ready = 0; m_mhz = 0; m_khz = 0; m_hz = 0; m_prog = 0;
         m_up = '0; m_act = 0; m_shadow = 0; m_next = 0;
      end else begin
         run_before = m_ready;
         prev_hz    = m_hz;
         t          = t + 1;
         m_ready    = (t > POR);
         rr         = t - POR - 1;   // edges since READY rose
         m_mhz      = (rr > 0) && (rr % US == 0);
         m_khz      = (rr > 0) && (rr % (US * MS) == 0);
         m_hz       = (rr > 0) && (rr % (US * MS * S) == 0);
         m_up       = m_up + {31'd0, prev_hz};
         m_prog     = 0;
         if (ld) m_shadow = per;
         if (ld && (m_act == 0 || !run_before)) begin
            m_act  = per;
            m_next = ((t > POR + 1) ? t : longint'(POR + 1)) + per;
         end else if (run_before && m_act != 0 && t == m_next) begin
            m_prog = 1;
            m_act  = m_shadow;
            m_next = t + m_act;
         end
      end
   endtask

   // One clock: update model, take the edge, compare every output.
   task automatic step();
      model_edge(rst, bus.PERIOD_LD, int'(bus.PERIOD));
      @(posedge clk);
      #1;
      chk("READY",     64'(bus.READY),     64'(m_ready));
      chk("TICK_1MHZ", 64'(bus.TICK_1MHZ), 64'(m_mhz));
      chk("TICK_1KHZ", 64'(bus.TICK_1KHZ), 64'(m_khz));
      chk("TICK_1HZ",  64'(bus.TICK_1HZ),  64'(m_hz));
      chk("TICK_PROG", 64'(bus.TICK_PROG), 64'(m_prog));
      chk("UPTIME_S",  64'(bus.UPTIME_S),  64'(m_up));
      if (rec_prog && bus.TICK_PROG) prog_edges.push_back(cur_e());
   endtask

   initial begin
      int first_ready, first_mhz, first_khz, first_hz;
      int cnt, n;
      int exp_edges[6];
      exp_edges = '{57, 64, 71, 74, 77, 80};

      bus.PERIOD    = '0;
      bus.PERIOD_LD = 1'b0;
      rst           = 1'b1;
      repeat (3) step();
      chk("rst_ready",  64'(bus.READY),    64'd0);
      chk("rst_uptime", 64'(bus.UPTIME_S), 64'd0);

      // Power-on stretch and first strobes.
      rst = 1'b0;
      first_ready = -1; first_mhz = -1; first_khz = -1; first_hz = -1;
      for (int i = 0; i < 46; i++) begin
         step();
         if (bus.READY     && first_ready < 0) first_ready = cur_e();
         if (bus.TICK_1MHZ && first_mhz   < 0) first_mhz   = cur_e();
         if (bus.TICK_1KHZ && first_khz   < 0) first_khz   = cur_e();
         if (bus.TICK_1HZ  && first_hz    < 0) first_hz    = cur_e();
      end
      chk("first_ready_edge", 64'(first_ready), 64'd16);
      chk("first_1mhz_edge",  64'(first_mhz),   64'd20);
      chk("first_1khz_edge",  64'(first_khz),   64'd28);
      chk("first_1hz_edge",   64'(first_hz),    64'd40);
      chk("uptime_after_1s",  64'(bus.UPTIME_S), 64'd1);

      // Period 7 loaded from disabled at edge 50, then 3 loaded mid-period at edge 66.
      while (cur_e() < 49) step();
      bus.PERIOD = 8'd7; bus.PERIOD_LD = 1'b1;
      rec_prog = 1'b1;
      step();
      bus.PERIOD_LD = 1'b0;
      while (cur_e() < 65) step();
      bus.PERIOD = 8'd3; bus.PERIOD_LD = 1'b1;
      step();
      bus.PERIOD_LD = 1'b0;
      while (cur_e() < 80) step();
      rec_prog = 1'b0;
      chk("prog_edge_count", 64'(prog_edges.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < prog_edges.size())
            chk($sformatf("prog_edge%0d", i), 64'(prog_edges[i]), 64'(exp_edges[i]));
      end

      // Period 1 -> strobe every cycle; then 0 -> stops after the completing strobe.
      bus.PERIOD = 8'd1; bus.PERIOD_LD = 1'b1;
      step();
      bus.PERIOD_LD = 1'b0;
      while (cur_e() < 85) step();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.TICK_PROG) cnt++;
      end
      chk("p1_every_cycle", 64'(cnt), 64'd10);
      bus.PERIOD = 8'd0; bus.PERIOD_LD = 1'b1;
      step();
      bus.PERIOD_LD = 1'b0;
      chk("p0_last_strobe", 64'(bus.TICK_PROG), 64'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.TICK_PROG) cnt++;
      end
      chk("p0_stopped", 64'(cnt), 64'd0);

      // Randomized loads and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         rst           = ($urandom_range(0, 399) == 0);
         bus.PERIOD_LD = ($urandom_range(0, 15) == 0);
         bus.PERIOD    = 8'($urandom_range(0, 12));
         step();
      end
      rst = 1'b0; bus.PERIOD_LD = 1'b0;

      // Mid-run reset coincident with a load.
      n = 0;
      while (!bus.READY && n < 40) begin step(); n++; end
      chk("ready_before_rst", 64'(bus.READY), 64'd1);
      repeat (30) step();
      rst = 1'b1; bus.PERIOD = 8'd5; bus.PERIOD_LD = 1'b1;
      step();
      rst = 1'b0; bus.PERIOD_LD = 1'b0;
      chk("rst_mid_ready",  64'(bus.READY),     64'd0);
      chk("rst_mid_mhz",    64'(bus.TICK_1MHZ), 64'd0);
      chk("rst_mid_prog",   64'(bus.TICK_PROG), 64'd0);
      chk("rst_mid_uptime", 64'(bus.UPTIME_S),  64'd0);
      first_ready = -1; cnt = 0; n = 0;
      while (n < 60) begin
         step();
         if (bus.READY && first_ready < 0) first_ready = cur_e();
         if (bus.TICK_PROG) cnt++;
         n++;
      end
      chk("por_restart_edge", 64'(first_ready), 64'd16);
      chk("prog_disabled_after_rst", 64'(cnt), 64'd0);

      // UPTIME_S wrap from all-ones.
      n = 0;
      while (!bus.TICK_1HZ && n < 60) begin step(); n++; end
      chk("hz_seen_before_force", 64'(bus.TICK_1HZ), 64'd1);
      step();
      force dut.uptime_q = 32'hFFFF_FFFF;
      m_up = 32'hFFFF_FFFF;
      step();
      release dut.uptime_q;
      n = 0;
      while (!bus.TICK_1HZ && n < 60) begin step(); n++; end
      chk("hz_seen_after_force", 64'(bus.TICK_1HZ), 64'd1);
      step();
      chk("uptime_wrap", 64'(bus.UPTIME_S), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
